// File: rtl/data_memory_bus_controller_if.sv
// Bus bundle between the load/store unit, the memory bus controller and the MMIO target.
//   slave  : controller side (accepts core requests, issues MMIO requests)
//   master : environment side (core plus MMIO target)
// Signals:
//   req_*   core request with valid/ready handshake
//   resp_*  single-cycle response pulse, no backpressure
//   mmio_*  registered MMIO request held until mmio_ready or timeout
interface data_memory_bus_controller_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_address;
   logic [31:0] req_write_data;
   logic [3:0]  req_byte_enable;
   logic        resp_valid;
   logic [31:0] resp_read_data;
   logic        resp_error;
   logic        mmio_valid;
   logic        mmio_write;
   logic [31:0] mmio_address;
   logic [31:0] mmio_write_data;
   logic [3:0]  mmio_byte_enable;
   logic        mmio_ready;
   logic [31:0] mmio_read_data;

   modport master (
      output req_valid, req_write, req_address, req_write_data, req_byte_enable,
      output mmio_ready, mmio_read_data,
      input  req_ready, resp_valid, resp_read_data, resp_error,
      input  mmio_valid, mmio_write, mmio_address, mmio_write_data, mmio_byte_enable
   );

   modport slave (
      input  req_valid, req_write, req_address, req_write_data, req_byte_enable,
      input  mmio_ready, mmio_read_data,
      output req_ready, resp_valid, resp_read_data, resp_error,
      output mmio_valid, mmio_write, mmio_address, mmio_write_data, mmio_byte_enable
   );
endinterface

// File: rtl/data_memory_bus_controller.sv
// Data memory bus controller: decodes core load/store requests to an internal byte-enabled
// RAM, an external MMIO port, or an error response for unmapped addresses.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : slave side of data_memory_bus_controller_if (core request/response + MMIO)
// One request is outstanding at most; every accepted request yields exactly one resp_valid
// pulse unless reset abandons it.
module data_memory_bus_controller #(
   parameter logic [31:0] DATA_BEGIN   = 32'h0001_0000,
   parameter logic [31:0] DATA_END     = 32'h0001_FFFF,
   parameter int unsigned DATA_BITS    = 16,
   parameter logic [31:0] MMIO_BEGIN   = 32'h8000_0000,
   parameter logic [31:0] MMIO_END     = 32'h8000_FFFF,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned MMIO_TIMEOUT = 16
) (
   input logic                         clock,
   input logic                         reset_n,
   data_memory_bus_controller_if.slave bus
);

   localparam int unsigned RamWords = 2 ** (DATA_BITS - 2);
   // Count value of the last MEM_WAIT / MMIO_WAIT cycle.
   localparam logic [2:0] MemCntLast  = 3'(READ_LATENCY - 2);
   localparam logic [7:0] MmioCntLast = 8'(MMIO_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StMemWait, StMmioWait} state_e;

   state_e      state_q, state_d;
   logic [2:0]  mem_cnt_q, mem_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_error_q, resp_error_d;
   logic [31:0] resp_read_data_q, resp_read_data_d;
   logic        mmio_valid_q, mmio_valid_d;
   logic        mmio_write_q, mmio_write_d;
   logic [31:0] mmio_address_q, mmio_address_d;
   logic [31:0] mmio_write_data_q, mmio_write_data_d;
   logic [3:0]  mmio_byte_enable_q, mmio_byte_enable_d;

   logic [31:0] mem_q [RamWords];

   logic                  req_ready;
   logic                  accept;
   logic [31:0]           addr_aligned;
   logic                  sel_ram;
   logic                  sel_mmio;
   logic [DATA_BITS-3:0]  ram_idx;
   logic [31:0]           ram_rdata;
   logic                  ram_we;

   assign req_ready    = reset_n && (state_q == StIdle);
   assign accept       = bus.req_valid && req_ready;
   assign addr_aligned = {bus.req_address[31:2], 2'b00};
   // RAM is checked first so it wins when the regions overlap.
   assign sel_ram      = (addr_aligned >= DATA_BEGIN) && (addr_aligned <= DATA_END);
   assign sel_mmio     = !sel_ram && (addr_aligned >= MMIO_BEGIN) && (addr_aligned <= MMIO_END);
   assign ram_idx      = bus.req_address[DATA_BITS-1:2];
   // Read is taken before the same-edge write lands, giving the pre-store word.
   assign ram_rdata    = mem_q[ram_idx];

   always_comb begin
      state_d            = state_q;
      mem_cnt_d          = mem_cnt_q;
      wait_cnt_d         = wait_cnt_q;
      mem_data_d         = mem_data_q;
      resp_valid_d       = 1'b0;
      resp_error_d       = 1'b0;
      resp_read_data_d   = '0;
      mmio_valid_d       = mmio_valid_q;
      mmio_write_d       = mmio_write_q;
      mmio_address_d     = mmio_address_q;
      mmio_write_data_d  = mmio_write_data_q;
      mmio_byte_enable_d = mmio_byte_enable_q;
      ram_we             = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (sel_ram) begin
                  ram_we = bus.req_write;
                  if (READ_LATENCY == 1) begin
                     resp_valid_d     = 1'b1;
                     resp_read_data_d = bus.req_write ? '0 : ram_rdata;
                  end else begin
                     state_d    = StMemWait;
                     mem_cnt_d  = '0;
                     mem_data_d = bus.req_write ? '0 : ram_rdata;
                  end
               end else if (sel_mmio) begin
                  state_d            = StMmioWait;
                  wait_cnt_d         = '0;
                  mmio_valid_d       = 1'b1;
                  mmio_write_d       = bus.req_write;
                  mmio_address_d     = bus.req_address;
                  mmio_write_data_d  = bus.req_write_data;
                  mmio_byte_enable_d = bus.req_byte_enable;
               end else begin
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
               end
            end
         end
         StMemWait: begin
            if (mem_cnt_q == MemCntLast) begin
               state_d          = StIdle;
               resp_valid_d     = 1'b1;
               resp_read_data_d = mem_data_q;
            end else begin
               mem_cnt_d = mem_cnt_q + 3'd1;
            end
         end
         StMmioWait: begin
            // Ready is checked before the timeout so a last-cycle ready still succeeds.
            if (bus.mmio_ready) begin
               state_d          = StIdle;
               mmio_valid_d     = 1'b0;
               resp_valid_d     = 1'b1;
               resp_read_data_d = mmio_write_q ? '0 : bus.mmio_read_data;
            end else if (wait_cnt_q == MmioCntLast) begin
               state_d      = StIdle;
               mmio_valid_d = 1'b0;
               resp_valid_d = 1'b1;
               resp_error_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q            <= StIdle;
         mem_cnt_q          <= '0;
         wait_cnt_q         <= '0;
         mem_data_q         <= '0;
         resp_valid_q       <= 1'b0;
         resp_error_q       <= 1'b0;
         resp_read_data_q   <= '0;
         mmio_valid_q       <= 1'b0;
         mmio_write_q       <= 1'b0;
         mmio_address_q     <= '0;
         mmio_write_data_q  <= '0;
         mmio_byte_enable_q <= '0;
      end else begin
         state_q            <= state_d;
         mem_cnt_q          <= mem_cnt_d;
         wait_cnt_q         <= wait_cnt_d;
         mem_data_q         <= mem_data_d;
         resp_valid_q       <= resp_valid_d;
         resp_error_q       <= resp_error_d;
         resp_read_data_q   <= resp_read_data_d;
         mmio_valid_q       <= mmio_valid_d;
         mmio_write_q       <= mmio_write_d;
         mmio_address_q     <= mmio_address_d;
         mmio_write_data_q  <= mmio_write_data_d;
         mmio_byte_enable_q <= mmio_byte_enable_d;
      end
   end

   // RAM array has no reset; ram_we already excludes reset through req_ready.
   always_ff @(posedge clock) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.req_byte_enable[i]) begin
               mem_q[ram_idx][8*i +: 8] <= bus.req_write_data[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready        = req_ready;
   assign bus.resp_valid       = resp_valid_q;
   assign bus.resp_error       = resp_error_q;
   assign bus.resp_read_data   = resp_read_data_q;
   assign bus.mmio_valid       = mmio_valid_q;
   assign bus.mmio_write       = mmio_write_q;
   assign bus.mmio_address     = mmio_address_q;
   assign bus.mmio_write_data  = mmio_write_data_q;
   assign bus.mmio_byte_enable = mmio_byte_enable_q;

endmodule

// File: tb/tb_data_memory_bus_controller.sv
// Directed bench for data_memory_bus_controller. Two instances: READ_LATENCY=1 (main) and
// READ_LATENCY=4 (latency check). Expected responses are queued with the cycle they are due.
module tb_data_memory_bus_controller;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   data_memory_bus_controller_if bus1 ();
   data_memory_bus_controller_if bus4 ();

   data_memory_bus_controller #(.READ_LATENCY(1)) u_dut1 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus1)
   );

   data_memory_bus_controller #(.READ_LATENCY(4)) u_dut4 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus4)
   );

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t q1[$];
   exp_t q4[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pop-and-compare for whichever instance has a response due this cycle.
   task automatic monitor();
      if (q1.size() != 0 && q1[0].due == cyc) begin
         chk("dut1 resp_valid", 32'(bus1.resp_valid), 32'd1);
         chk("dut1 resp_read_data", bus1.resp_read_data, q1[0].data);
         chk("dut1 resp_error", 32'(bus1.resp_error), 32'(q1[0].err));
         void'(q1.pop_front());
      end else begin
         chk("dut1 no resp_valid", 32'(bus1.resp_valid), 32'd0);
      end
      if (q4.size() != 0 && q4[0].due == cyc) begin
         chk("dut4 resp_valid", 32'(bus4.resp_valid), 32'd1);
         chk("dut4 resp_read_data", bus4.resp_read_data, q4[0].data);
         chk("dut4 resp_error", 32'(bus4.resp_error), 32'(q4[0].err));
         void'(q4.pop_front());
      end else begin
         chk("dut4 no resp_valid", 32'(bus4.resp_valid), 32'd0);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      monitor();
   endtask

   // Present a request on dut1 for one edge; req_valid is left high for back-to-back use.
   task automatic issue1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int due_off, input logic [31:0] exp_data,
                         input logic exp_err, input logic push);
      bus1.req_valid       = 1'b1;
      bus1.req_write       = wr;
      bus1.req_address     = addr;
      bus1.req_write_data  = wdata;
      bus1.req_byte_enable = be;
      chk("dut1 req_ready at request", 32'(bus1.req_ready), 32'd1);
      if (push) q1.push_back(exp_t'{due: cyc + due_off, data: exp_data, err: exp_err});
      step();
   endtask

   task automatic issue4(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data);
      bus4.req_valid       = 1'b1;
      bus4.req_write       = wr;
      bus4.req_address     = addr;
      bus4.req_write_data  = wdata;
      bus4.req_byte_enable = 4'hF;
      chk("dut4 req_ready at request", 32'(bus4.req_ready), 32'd1);
      q4.push_back(exp_t'{due: cyc + 4, data: exp_data, err: 1'b0});
      step();
      bus4.req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("dut4 req_ready low while waiting", 32'(bus4.req_ready), 32'd0);
         step();
      end
      chk("dut4 req_ready in response cycle", 32'(bus4.req_ready), 32'd1);
   endtask

   initial begin
      int vcount;
      bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_address = '0;
      bus1.req_write_data = '0; bus1.req_byte_enable = '0;
      bus1.mmio_ready = 1'b0; bus1.mmio_read_data = '0;
      bus4.req_valid = 1'b0; bus4.req_write = 1'b0; bus4.req_address = '0;
      bus4.req_write_data = '0; bus4.req_byte_enable = '0;
      bus4.mmio_ready = 1'b0; bus4.mmio_read_data = '0;

      // Reset state
      step();
      step();
      chk("reset req_ready", 32'(bus1.req_ready), 32'd0);
      chk("reset resp_error", 32'(bus1.resp_error), 32'd0);
      chk("reset resp_read_data", bus1.resp_read_data, 32'd0);
      chk("reset mmio_valid", 32'(bus1.mmio_valid), 32'd0);
      chk("reset mmio_write", 32'(bus1.mmio_write), 32'd0);
      chk("reset mmio_address", bus1.mmio_address, 32'd0);
      chk("reset mmio_write_data", bus1.mmio_write_data, 32'd0);
      chk("reset mmio_byte_enable", 32'(bus1.mmio_byte_enable), 32'd0);
      reset_n = 1'b1;
      #1;
      chk("req_ready after reset", 32'(bus1.req_ready), 32'd1);

      // Back-to-back store then load, plus a load with nonzero low address bits
      issue1(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 1'b0, 1'b1);
      issue1(1'b0, 32'h0001_0010, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b1);
      issue1(1'b0, 32'h0001_0013, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b1);

      // Byte lanes
      issue1(1'b1, 32'h0001_0014, 32'h1122_3344, 4'hF, 1, 32'h0, 1'b0, 1'b1);
      issue1(1'b1, 32'h0001_0014, 32'hAABB_CCDD, 4'b0101, 1, 32'h0, 1'b0, 1'b1);
      issue1(1'b0, 32'h0001_0014, 32'h0, 4'h0, 1, 32'h11BB_33DD, 1'b0, 1'b1);
      bus1.req_valid = 1'b0;
      step();

      // Unmapped load
      issue1(1'b0, 32'h4000_0000, 32'h0, 4'h0, 1, 32'h0, 1'b1, 1'b1);
      bus1.req_valid = 1'b0;
      chk("unmapped mmio_valid", 32'(bus1.mmio_valid), 32'd0);
      step();
      chk("unmapped mmio_valid later", 32'(bus1.mmio_valid), 32'd0);

      // mmio_ready while idle must be ignored
      bus1.mmio_ready = 1'b1;
      bus1.mmio_read_data = 32'h1234_5678;
      step();
      step();
      bus1.mmio_ready = 1'b0;

      // MMIO load, ready on 3rd cycle of mmio_valid
      issue1(1'b0, 32'h8000_0004, 32'h0, 4'hF, 4, 32'h0000_00A5, 1'b0, 1'b1);
      bus1.req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("mmio load mmio_valid", 32'(bus1.mmio_valid), 32'd1);
         chk("mmio load mmio_address", bus1.mmio_address, 32'h8000_0004);
         chk("mmio load mmio_write", 32'(bus1.mmio_write), 32'd0);
         if (i == 2) begin
            bus1.mmio_ready = 1'b1;
            bus1.mmio_read_data = 32'h0000_00A5;
         end
         step();
      end
      bus1.mmio_ready = 1'b0;
      bus1.mmio_read_data = 32'h0;
      chk("mmio load mmio_valid dropped", 32'(bus1.mmio_valid), 32'd0);

      // MMIO store, ready on first cycle; response data must be 0
      issue1(1'b1, 32'h8000_0008, 32'h1234_5678, 4'b0011, 2, 32'h0, 1'b0, 1'b1);
      bus1.req_valid = 1'b0;
      chk("mmio store mmio_write", 32'(bus1.mmio_write), 32'd1);
      chk("mmio store mmio_write_data", bus1.mmio_write_data, 32'h1234_5678);
      chk("mmio store mmio_byte_enable", 32'(bus1.mmio_byte_enable), 32'h3);
      bus1.mmio_ready = 1'b1;
      bus1.mmio_read_data = 32'hFFFF_FFFF;
      step();
      bus1.mmio_ready = 1'b0;

      // MMIO timeout: mmio_valid high exactly 16 cycles, then error response
      issue1(1'b0, 32'h8000_0010, 32'h0, 4'hF, 17, 32'h0, 1'b1, 1'b1);
      bus1.req_valid = 1'b0;
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         if (!bus1.mmio_valid) break;
         vcount++;
         step();
      end
      chk("timeout mmio_valid cycles", 32'(vcount), 32'd16);

      // Latency 4 on the second instance
      issue4(1'b1, 32'h0001_0020, 32'hCAFE_F00D, 32'h0);
      issue4(1'b0, 32'h0001_0020, 32'h0, 32'hCAFE_F00D);
      step();

      // Reset mid-MMIO: request abandoned, no response
      issue1(1'b0, 32'h8000_0020, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
      bus1.req_valid = 1'b0;
      chk("pre-reset mmio_valid", 32'(bus1.mmio_valid), 32'd1);
      step();
      reset_n = 1'b0;
      step();
      chk("mid-reset mmio_valid", 32'(bus1.mmio_valid), 32'd0);
      chk("mid-reset req_ready", 32'(bus1.req_ready), 32'd0);
      reset_n = 1'b1;
      #1;
      chk("post-reset req_ready", 32'(bus1.req_ready), 32'd1);
      for (int i = 0; i < 20; i++) step();
      chk("post-reset mmio_valid", 32'(bus1.mmio_valid), 32'd0);

      chk("dut1 scoreboard drained", 32'(q1.size()), 32'd0);
      chk("dut4 scoreboard drained", 32'(q4.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
